// File: rtl/bellek_islem_birimi_pkg.sv
// rtl/bellek_islem_birimi_pkg.sv - size codes, islem bit positions, FSM states and lane helpers
package bellek_islem_birimi_pkg;

  localparam logic [1:0] BOYUT_B = 2'b00;
  localparam logic [1:0] BOYUT_H = 2'b01;
  localparam logic [1:0] BOYUT_W = 2'b10;
  localparam logic [1:0] BOYUT_X = 2'b11;

  localparam int ISLEM_YAZ       = 3;
  localparam int ISLEM_ISARETSIZ = 2;

  typedef enum logic {
    BOSTA     = 1'b0,
    OKU_BEKLE = 1'b1
  } durum_t;

  function automatic logic hizasiz(input logic [1:0] boyut, input logic [1:0] off);
    return (boyut == BOYUT_H && off[0]) || (boyut == BOYUT_W && off != 2'b00) ||
           (boyut == BOYUT_X);
  endfunction

  function automatic logic [3:0] yaz_maske(input logic [1:0] boyut, input logic [1:0] off);
    case (boyut)
      BOYUT_B: return 4'b0001 << off;
      BOYUT_H: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow datum across lanes lets the mask alone pick the target bytes.
  function automatic logic [31:0] yaz_veri(input logic [1:0] boyut, input logic [31:0] veri);
    case (boyut)
      BOYUT_B: return {4{veri[7:0]}};
      BOYUT_H: return {2{veri[15:0]}};
      default: return veri;
    endcase
  endfunction

endpackage

// File: rtl/bellek_islem_birimi_if.sv
// rtl/bellek_islem_birimi_if.sv - request/response bus between the load/store unit and the data-path unit
interface bellek_islem_birimi_if;
  logic        bib_istek_gecerli_o;
  logic        bib_istek_yaz_o;
  logic        bib_istek_oku_o;
  logic [31:0] bib_istek_adres_o;
  logic [3:0]  bib_istek_maske_o;
  logic [31:0] bib_veri_o;
  logic        bellek_hazir_i;
  logic [31:0] bellek_veri_i;
  logic        bellek_gecerli_i;

  modport master (
    output bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
    output bib_istek_adres_o, bib_istek_maske_o, bib_veri_o,
    input  bellek_hazir_i, bellek_veri_i, bellek_gecerli_i
  );

  modport slave (
    input  bib_istek_gecerli_o, bib_istek_yaz_o, bib_istek_oku_o,
    input  bib_istek_adres_o, bib_istek_maske_o, bib_veri_o,
    output bellek_hazir_i, bellek_veri_i, bellek_gecerli_i
  );
endinterface

// File: rtl/bellek_islem_birimi_veri_hizalayici.sv
// rtl/bellek_islem_birimi_veri_hizalayici.sv - selects the addressed byte/half of a read word and extends it
module bib_veri_hizalayici
  import bellek_islem_birimi_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  boyut_i,
  input  logic        isaretsiz_i,
  input  logic [31:0] kelime_i,
  output logic [31:0] sonuc_o
);
  logic [7:0]  bayt;
  logic [15:0] yarim;

  always_comb begin
    bayt    = kelime_i[{off_i, 3'b000} +: 8];
    yarim   = off_i[1] ? kelime_i[31:16] : kelime_i[15:0];
    sonuc_o = kelime_i;
    case (boyut_i)
      BOYUT_B: sonuc_o = isaretsiz_i ? {24'h0, bayt} : {{24{bayt[7]}}, bayt};
      BOYUT_H: sonuc_o = isaretsiz_i ? {16'h0, yarim} : {{16{yarim[15]}}, yarim};
      default: sonuc_o = kelime_i;
    endcase
  end
endmodule

// File: rtl/bellek_islem_birimi.sv
// rtl/bellek_islem_birimi.sv - memory-stage load/store front end: request shaping, stall and load return
module bellek_islem_birimi
  import bellek_islem_birimi_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ybib_gecerli_i,
  input  logic [3:0]                   ybib_islem_i,
  input  logic [31:0]                  ybib_adres_i,
  input  logic [31:0]                  ybib_veri_i,
  input  logic [4:0]                   ybib_yazmac_i,
  output logic                         durdur_o,
  output logic                         sonuc_gecerli_o,
  output logic [31:0]                  sonuc_o,
  output logic [4:0]                   sonuc_yazmac_o,
  output logic                         hiza_hatasi_o,
  output logic [31:0]                  hata_adres_o,
  bellek_islem_birimi_if.master        bib
);
  logic [1:0] off, boyut;
  logic       yaz, isaretsiz;

  assign off       = ybib_adres_i[1:0];
  assign boyut     = ybib_islem_i[1:0];
  assign yaz       = ybib_islem_i[ISLEM_YAZ];
  assign isaretsiz = ybib_islem_i[ISLEM_ISARETSIZ];

  durum_t      durum_q, durum_d;
  logic [1:0]  off_q, off_d, boyut_q, boyut_d;
  logic        isaretsiz_q, isaretsiz_d;
  logic [4:0]  yazmac_q, yazmac_d, sonuc_yazmac_q, sonuc_yazmac_d;
  logic [31:0] sonuc_q, sonuc_d, cikarilan;
  logic        sonuc_gecerli_q, sonuc_gecerli_d;

  bib_veri_hizalayici u_hizalayici (
    .off_i       (off_q),
    .boyut_i     (boyut_q),
    .isaretsiz_i (isaretsiz_q),
    .kelime_i    (bib.bellek_veri_i),
    .sonuc_o     (cikarilan)
  );

  always_comb begin
    durum_d                 = durum_q;
    off_d                   = off_q;
    boyut_d                 = boyut_q;
    isaretsiz_d             = isaretsiz_q;
    yazmac_d                = yazmac_q;
    sonuc_d                 = sonuc_q;
    sonuc_yazmac_d          = sonuc_yazmac_q;
    sonuc_gecerli_d         = 1'b0;
    durdur_o                = 1'b0;
    hiza_hatasi_o           = 1'b0;
    hata_adres_o            = 32'h0;
    bib.bib_istek_gecerli_o = 1'b0;
    bib.bib_istek_yaz_o     = 1'b0;
    bib.bib_istek_oku_o     = 1'b0;
    bib.bib_istek_adres_o   = 32'h0;
    bib.bib_istek_maske_o   = 4'h0;
    bib.bib_veri_o          = 32'h0;
    if (!rst_i) begin
      case (durum_q)
        BOSTA: begin
          if (ybib_gecerli_i && hizasiz(boyut, off)) begin
            hiza_hatasi_o = 1'b1;
            hata_adres_o  = ybib_adres_i;
          end else if (ybib_gecerli_i) begin
            bib.bib_istek_gecerli_o = 1'b1;
            bib.bib_istek_yaz_o     = yaz;
            bib.bib_istek_oku_o     = !yaz;
            bib.bib_istek_adres_o   = ybib_adres_i;
            bib.bib_istek_maske_o   = yaz ? yaz_maske(boyut, off) : 4'b1111;
            bib.bib_veri_o          = yaz ? yaz_veri(boyut, ybib_veri_i) : 32'h0;
            // An accepted store retires now; a load holds the pipe until its word returns.
            durdur_o = !bib.bellek_hazir_i || !yaz;
            if (bib.bellek_hazir_i && !yaz) begin
              durum_d     = OKU_BEKLE;
              off_d       = off;
              boyut_d     = boyut;
              isaretsiz_d = isaretsiz;
              yazmac_d    = ybib_yazmac_i;
            end
          end
        end
        OKU_BEKLE: begin
          durdur_o = 1'b1;
          if (bib.bellek_gecerli_i) begin
            sonuc_d         = cikarilan;
            sonuc_yazmac_d  = yazmac_q;
            sonuc_gecerli_d = 1'b1;
            durum_d         = BOSTA;
          end
        end
        default: durum_d = BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      off_q           <= 2'b00;
      boyut_q         <= BOYUT_B;
      isaretsiz_q     <= 1'b0;
      yazmac_q        <= 5'd0;
      sonuc_q         <= 32'h0;
      sonuc_yazmac_q  <= 5'd0;
      sonuc_gecerli_q <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      off_q           <= off_d;
      boyut_q         <= boyut_d;
      isaretsiz_q     <= isaretsiz_d;
      yazmac_q        <= yazmac_d;
      sonuc_q         <= sonuc_d;
      sonuc_yazmac_q  <= sonuc_yazmac_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
    end
  end

  assign sonuc_o         = sonuc_q;
  assign sonuc_yazmac_o  = sonuc_yazmac_q;
  assign sonuc_gecerli_o = sonuc_gecerli_q;
endmodule

// File: tb/tb_bellek_islem_birimi.sv
// tb/tb_bellek_islem_birimi.sv - directed vector bench for bellek_islem_birimi
module tb_bellek_islem_birimi;
  logic        clk = 1'b0;
  logic        rst;
  logic        gecerli;
  logic [3:0]  islem;
  logic [31:0] adres, veri;
  logic [4:0]  yazmac;
  logic        durdur, sonuc_gecerli, hiza;
  logic [31:0] sonuc, hata_adres;
  logic [4:0]  sonuc_yazmac;

  int gecen = 0;
  int toplam = 0;

  bellek_islem_birimi_if bus ();

  bellek_islem_birimi dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ybib_gecerli_i  (gecerli),
    .ybib_islem_i    (islem),
    .ybib_adres_i    (adres),
    .ybib_veri_i     (veri),
    .ybib_yazmac_i   (yazmac),
    .durdur_o        (durdur),
    .sonuc_gecerli_o (sonuc_gecerli),
    .sonuc_o         (sonuc),
    .sonuc_yazmac_o  (sonuc_yazmac),
    .hiza_hatasi_o   (hiza),
    .hata_adres_o    (hata_adres),
    .bib             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gecerli;
    logic [3:0]  islem;
    logic [31:0] adres;
    logic [31:0] veri;
    logic        hazir;
    logic        ig, yaz, oku;
    logic [3:0]  maske;
    logic [31:0] bveri;
    logic        durdur, hiza;
    logic [31:0] hata;
  } vektor_t;

  vektor_t tablo [9];

  task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek !== beklenen)
      $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
    else
      gecen++;
  endtask

  task automatic adim;
    @(posedge clk);
    #1;
  endtask

  task automatic yukle(input string ad, input logic [3:0] op, input logic [31:0] adr,
                       input logic [4:0] rd, input logic [31:0] kelime, input logic [31:0] bek);
    adim();
    gecerli = 1'b1; islem = op; adres = adr; yazmac = rd; veri = 32'h0;
    bus.bellek_hazir_i = 1'b1; bus.bellek_gecerli_i = 1'b0;
    @(negedge clk);
    chk({ad, " oku"}, {31'h0, bus.bib_istek_oku_o}, 32'd1);
    chk({ad, " maske"}, {28'h0, bus.bib_istek_maske_o}, 32'hF);
    chk({ad, " durdur T"}, {31'h0, durdur}, 32'd1);
    adim();
    bus.bellek_gecerli_i = 1'b1; bus.bellek_veri_i = kelime;
    @(negedge clk);
    chk({ad, " durdur T+1"}, {31'h0, durdur}, 32'd1);
    chk({ad, " istek T+1"}, {31'h0, bus.bib_istek_gecerli_o}, 32'd0);
    adim();
    gecerli = 1'b0; bus.bellek_gecerli_i = 1'b0; bus.bellek_veri_i = 32'h0;
    @(negedge clk);
    chk({ad, " sonuc_gecerli"}, {31'h0, sonuc_gecerli}, 32'd1);
    chk({ad, " sonuc"}, sonuc, bek);
    chk({ad, " sonuc_yazmac"}, {27'h0, sonuc_yazmac}, {27'h0, rd});
    chk({ad, " durdur T+2"}, {31'h0, durdur}, 32'd0);
    adim();
    @(negedge clk);
    chk({ad, " tek darbe"}, {31'h0, sonuc_gecerli}, 32'd0);
  endtask

  initial begin
    tablo[0] = '{1'b1, 4'b1000, 32'h1003, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 32'hDDDDDDDD, 1'b0, 1'b0, 32'h0};
    tablo[1] = '{1'b1, 4'b1001, 32'h1002, 32'h11223344, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h33443344, 1'b0, 1'b0, 32'h0};
    tablo[2] = '{1'b1, 4'b1010, 32'h1000, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h12345678, 1'b0, 1'b0, 32'h0};
    tablo[3] = '{1'b1, 4'b1000, 32'h1000, 32'h000000A5, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    tablo[4] = '{1'b1, 4'b0010, 32'h4002, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h4002};
    tablo[5] = '{1'b1, 4'b0011, 32'h4000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h4000};
    tablo[6] = '{1'b1, 4'b1001, 32'h1001, 32'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h1001};
    tablo[7] = '{1'b0, 4'b1010, 32'h5555, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
    tablo[8] = '{1'b1, 4'b0010, 32'h2000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h0};

    rst = 1'b1; gecerli = 1'b1; islem = 4'b1010; adres = 32'h100; veri = 32'hFFFF; yazmac = 5'd0;
    bus.bellek_hazir_i = 1'b1; bus.bellek_veri_i = 32'h0; bus.bellek_gecerli_i = 1'b0;
    @(negedge clk);
    chk("reset istek", {31'h0, bus.bib_istek_gecerli_o}, 32'd0);
    chk("reset maske", {28'h0, bus.bib_istek_maske_o}, 32'd0);
    chk("reset durdur", {31'h0, durdur}, 32'd0);
    adim();
    rst = 1'b0; gecerli = 1'b0;
    @(negedge clk);
    chk("reset sonuc_gecerli", {31'h0, sonuc_gecerli}, 32'd0);
    chk("reset sonuc", sonuc, 32'h0);
    chk("reset hata_adres", hata_adres, 32'h0);

    for (int i = 0; i < 9; i++) begin
      adim();
      gecerli = tablo[i].gecerli; islem = tablo[i].islem; adres = tablo[i].adres;
      veri = tablo[i].veri; bus.bellek_hazir_i = tablo[i].hazir;
      @(negedge clk);
      chk($sformatf("v%0d istek", i), {31'h0, bus.bib_istek_gecerli_o}, {31'h0, tablo[i].ig});
      chk($sformatf("v%0d yaz", i), {31'h0, bus.bib_istek_yaz_o}, {31'h0, tablo[i].yaz});
      chk($sformatf("v%0d oku", i), {31'h0, bus.bib_istek_oku_o}, {31'h0, tablo[i].oku});
      chk($sformatf("v%0d maske", i), {28'h0, bus.bib_istek_maske_o}, {28'h0, tablo[i].maske});
      chk($sformatf("v%0d bib_veri", i), bus.bib_veri_o, tablo[i].bveri);
      chk($sformatf("v%0d durdur", i), {31'h0, durdur}, {31'h0, tablo[i].durdur});
      chk($sformatf("v%0d hiza", i), {31'h0, hiza}, {31'h0, tablo[i].hiza});
      chk($sformatf("v%0d hata_adres", i), hata_adres, tablo[i].hata);
      if (tablo[i].ig)
        chk($sformatf("v%0d adres", i), bus.bib_istek_adres_o, tablo[i].adres);
    end
    adim();
    gecerli = 1'b0; bus.bellek_hazir_i = 1'b1;

    yukle("LH", 4'b0001, 32'h2002, 5'd7, 32'h80017F00, 32'hFFFF8001);
    yukle("LBU", 4'b0100, 32'h3001, 5'd9, 32'h0000F100, 32'h000000F1);
    yukle("LB", 4'b0000, 32'h3001, 5'd10, 32'h0000F100, 32'hFFFFFFF1);
    yukle("LW", 4'b0010, 32'h3004, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF);

    // Store stalled three cycles, with a stray completion pulse while idle.
    for (int c = 0; c < 4; c++) begin
      adim();
      gecerli = 1'b1; islem = 4'b1010; adres = 32'h6000; veri = 32'hCAFEBABE;
      bus.bellek_hazir_i = (c == 3);
      bus.bellek_gecerli_i = (c == 1);
      @(negedge clk);
      chk($sformatf("SW c%0d istek", c), {31'h0, bus.bib_istek_gecerli_o}, 32'd1);
      chk($sformatf("SW c%0d veri", c), bus.bib_veri_o, 32'hCAFEBABE);
      chk($sformatf("SW c%0d durdur", c), {31'h0, durdur}, (c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("SW c%0d sonuc_gecerli", c), {31'h0, sonuc_gecerli}, 32'd0);
    end
    adim();
    gecerli = 1'b0; bus.bellek_gecerli_i = 1'b0;
    @(negedge clk);
    chk("SW sonra sonuc_gecerli", {31'h0, sonuc_gecerli}, 32'd0);

    // Reset while a load is outstanding.
    adim();
    gecerli = 1'b1; islem = 4'b0010; adres = 32'h7000; yazmac = 5'd3; bus.bellek_hazir_i = 1'b1;
    @(negedge clk);
    chk("RST yuk kabul", {31'h0, durdur}, 32'd1);
    adim();
    rst = 1'b1; gecerli = 1'b0;
    @(negedge clk);
    chk("RST durdur", {31'h0, durdur}, 32'd0);
    chk("RST istek", {31'h0, bus.bib_istek_gecerli_o}, 32'd0);
    adim();
    rst = 1'b0; bus.bellek_gecerli_i = 1'b1; bus.bellek_veri_i = 32'h12345678;
    @(negedge clk);
    chk("RST sonra durdur", {31'h0, durdur}, 32'd0);
    chk("RST sonra sonuc", sonuc, 32'h0);
    adim();
    bus.bellek_gecerli_i = 1'b0;
    @(negedge clk);
    chk("RST gec yanit", {31'h0, sonuc_gecerli}, 32'd0);
    chk("RST sonuc korunur", sonuc, 32'h0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end
endmodule
